// File: rtl/axi_reg_slave.sv
// AXI4-Lite register responder for the MAC configuration file.
// It exposes every register on a flat bus and pulses a notify strobe on each committed write.
module axi_reg_slave #(
  parameter int NUM_REGS = 128,
  parameter int REG_W    = 16
) (
  input  logic                      Clk_reg,
  input  logic                      Reset,
  input  logic [31:0]               S_AXI_awaddr,
  input  logic                      S_AXI_awvalid,
  output logic                      S_AXI_awready,
  input  logic [31:0]               S_AXI_wdata,
  input  logic                      S_AXI_wvalid,
  output logic                      S_AXI_wready,
  output logic [1:0]                S_AXI_bresp,
  output logic                      S_AXI_bvalid,
  input  logic                      S_AXI_bready,
  input  logic [31:0]               S_AXI_araddr,
  input  logic                      S_AXI_arvalid,
  output logic                      S_AXI_arready,
  output logic [31:0]               S_AXI_rdata,
  output logic [1:0]                S_AXI_rresp,
  output logic                      S_AXI_rvalid,
  input  logic                      S_AXI_rready,
  output logic [NUM_REGS*REG_W-1:0] Reg_bus,
  output logic                      Wr_strobe,
  output logic [6:0]                Wr_index
);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [29:0] NREGS = 30'(NUM_REGS);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  wstate_t wstate, wnext;
  rstate_t rstate, rnext;

  logic             live;
  logic [REG_W-1:0] regs [NUM_REGS];
  logic [29:0]      aw_lat, c_idx, ar_idx;
  logic [REG_W-1:0] w_lat, c_data;
  logic             aw_hs, w_hs, ar_hs, commit, c_ok, ar_ok;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_awaddr[1:0], S_AXI_araddr[1:0], S_AXI_wdata[31:REG_W]};

  assign aw_hs  = S_AXI_awvalid & S_AXI_awready;
  assign w_hs   = S_AXI_wvalid  & S_AXI_wready;
  assign ar_hs  = S_AXI_arvalid & S_AXI_arready;
  assign ar_idx = S_AXI_araddr[31:2];
  assign ar_ok  = ar_idx < NREGS;

  // Commit source: whichever half was parked earlier comes from the latch.
  assign commit = (wstate == W_IDLE    && aw_hs && w_hs) ||
                  (wstate == W_WAIT_W  && w_hs) ||
                  (wstate == W_WAIT_AW && aw_hs);
  assign c_idx  = (wstate == W_WAIT_W)  ? aw_lat : S_AXI_awaddr[31:2];
  assign c_data = (wstate == W_WAIT_AW) ? w_lat  : S_AXI_wdata[REG_W-1:0];
  assign c_ok   = c_idx < NREGS;

  // READYs stay low until the first edge after reset release.
  always_ff @(posedge Clk_reg or negedge Reset)
    if (!Reset) live <= 1'b0;
    else        live <= 1'b1;

  always_ff @(posedge Clk_reg or negedge Reset)
    if (!Reset) wstate <= W_IDLE;
    else        wstate <= wnext;

  always_comb begin
    wnext = wstate;
    case (wstate)
      W_IDLE: begin
        if (aw_hs && w_hs) wnext = W_RESP;
        else if (aw_hs)    wnext = W_WAIT_W;
        else if (w_hs)     wnext = W_WAIT_AW;
      end
      W_WAIT_W:  if (w_hs)         wnext = W_RESP;
      W_WAIT_AW: if (aw_hs)        wnext = W_RESP;
      W_RESP:    if (S_AXI_bready) wnext = W_IDLE;
      default:                     wnext = W_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_awready = 1'b0;
    S_AXI_wready  = 1'b0;
    S_AXI_bvalid  = 1'b0;
    case (wstate)
      W_IDLE:    begin S_AXI_awready = live; S_AXI_wready = live; end
      W_WAIT_W:  S_AXI_wready  = 1'b1;
      W_WAIT_AW: S_AXI_awready = 1'b1;
      W_RESP:    S_AXI_bvalid  = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge Clk_reg or negedge Reset)
    if (!Reset) begin
      aw_lat      <= '0;
      w_lat       <= '0;
      S_AXI_bresp <= OKAY;
      Wr_strobe   <= 1'b0;
      Wr_index    <= '0;
    end else begin
      if (wstate == W_IDLE && aw_hs && !w_hs) aw_lat <= S_AXI_awaddr[31:2];
      if (wstate == W_IDLE && w_hs && !aw_hs) w_lat  <= S_AXI_wdata[REG_W-1:0];
      Wr_strobe <= commit && c_ok;
      if (commit) begin
        S_AXI_bresp <= c_ok ? OKAY : SLVERR;
        if (c_ok) Wr_index <= 7'(c_idx);
      end
    end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    always_ff @(posedge Clk_reg or negedge Reset)
      if (!Reset)                          regs[i] <= '0;
      else if (commit && c_idx == 30'(i))  regs[i] <= c_data;
    assign Reg_bus[i*REG_W +: REG_W] = regs[i];
  end

  always_ff @(posedge Clk_reg or negedge Reset)
    if (!Reset) rstate <= R_IDLE;
    else        rstate <= rnext;

  always_comb begin
    rnext = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs)        rnext = R_RESP;
      R_RESP:  if (S_AXI_rready) rnext = R_IDLE;
      default:                   rnext = R_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_arready = (rstate == R_IDLE) && live;
    S_AXI_rvalid  = (rstate == R_RESP);
  end

  // Reads sample the array before this edge's write lands, so same-edge hits return the old value.
  always_ff @(posedge Clk_reg or negedge Reset)
    if (!Reset) begin
      S_AXI_rdata <= '0;
      S_AXI_rresp <= OKAY;
    end else if (ar_hs) begin
      S_AXI_rdata <= ar_ok ? 32'(regs[ar_idx[IW-1:0]]) : 32'h0;
      S_AXI_rresp <= ar_ok ? OKAY : SLVERR;
    end
endmodule

// File: doc/axi_reg_slave.md
# axi_reg_slave

AXI4-Lite responder that terminates the register-access port driven by the host/CPU side of the MAC testbench and design. It holds the MAC configuration register file and returns write/read responses. It exposes every register as a flat bus plus a one-cycle write-notify strobe for side effects. It must accept single-cycle VALID pulses: the initiator drops AWVALID, WVALID and ARVALID after one clock regardless of READY. To support this, the block holds its READY outputs high while idle.

## Interface
- NUM_REGS, 128, number of registers; word index = addr[31:2], valid range 0..NUM_REGS-1
- REG_W, 16, register width; occupies wdata/rdata[REG_W-1:0]
- Clk_reg  input  1  register clock; all state on rising edge
- Reset  input  1  asynchronous, active-low reset
- S_AXI_awaddr  input  32  write address; bits [1:0] ignored
- S_AXI_awvalid / S_AXI_awready  input / output  1  write-address handshake
- S_AXI_wdata  input  32  write data; bits [31:REG_W] ignored
- S_AXI_wvalid / S_AXI_wready  input / output  1  write-data handshake
- S_AXI_bresp  output  2  write response, 2'b00 OKAY, 2'b10 SLVERR
- S_AXI_bvalid / S_AXI_bready  output / input  1  write-response handshake
- S_AXI_araddr  input  32  read address; bits [1:0] ignored
- S_AXI_arvalid / S_AXI_arready  input / output  1  read-address handshake
- S_AXI_rdata  output  32  read data, zero-extended
- S_AXI_rresp  output  2  read response, same encoding as bresp
- S_AXI_rvalid / S_AXI_rready  output / input  1  read-data handshake
- Reg_bus  output  NUM_REGS*REG_W  register i at [i*REG_W +: REG_W]
- Wr_strobe  output  1  one-cycle pulse on each committed in-range write
- Wr_index  output  7  index of the register written; valid while Wr_strobe=1

## Operation
- Reset (Reset=0, asynchronous) sets:
  - all registers, Reg_bus, bvalid, rvalid, bresp, rresp, rdata, Wr_strobe and Wr_index to 0
  - awready, wready and arready to 0
- All READY outputs rise on the first clock edge after Reset deasserts.
- The write FSM has states W_IDLE, W_WAIT_W, W_WAIT_AW and W_RESP:
  - W_IDLE: awready=1, wready=1.
    - AW and W handshakes on the same edge: commit, go to W_RESP.
    - AW only: latch the address, go to W_WAIT_W.
    - W only: latch the data, go to W_WAIT_AW.
  - W_WAIT_W: awready=0, wready=1. Commit when the W handshake occurs, then go to W_RESP.
  - W_WAIT_AW: awready=1, wready=0. Commit when the AW handshake occurs, then go to W_RESP.
  - W_RESP: awready=wready=0, bvalid=1. bvalid and bresp are held until bready=1 is sampled, then go to W_IDLE.
- Commit behaviour:
  - Index < NUM_REGS: write wdata[REG_W-1:0] to the register, pulse Wr_strobe for one cycle with Wr_index set, bresp=OKAY.
  - Index out of range: no register change, no strobe, bresp=SLVERR.
- The read FSM has states R_IDLE and R_RESP:
  - R_IDLE: arready=1. On the AR handshake, register rdata/rresp and go to R_RESP.
  - R_RESP: arready=0, rvalid=1, rdata and rresp held until rready=1 is sampled, then go to R_IDLE.
  - Out-of-range read: rdata=0, rresp=SLVERR.
- The read and write FSMs are independent and may be active together.

## Timing
- Write latency: with valids sampled at edge N, the register, Reg_bus, Wr_strobe and bvalid all update at edge N.
- Write with bready=1: the B handshake occurs at edge N+1, and awready/wready are back to 1 after edge N+1.
- Read latency: with AR sampled at edge N, rvalid and rdata are valid after edge N. With rready=1, arready is back to 1 after edge N+1.
- Minimum back-to-back spacing is 2 cycles per transaction on each channel.
- Read and write to the same register at the same edge: the read returns the pre-write value.
- A VALID pulse arriving while its READY is 0 is lost. There is no error flag; the initiator must not issue a new request before the previous response completes.
- Reset asserted mid-transaction:
  - Immediate return to W_IDLE/R_IDLE with all outputs at reset values.
  - The pending response is dropped and any uncommitted data is discarded.
- Wr_index is 7 bits wide, which covers NUM_REGS up to 128.

## Test plan
- Write/readback: write index 5 = 16'hA5C3 with 1-cycle aw/w valid and bready=1.
  - Expected: bvalid=1 for 1 cycle, bresp=00, Reg_bus[95:80]=A5C3, Wr_strobe=1 with Wr_index=5.
  - Read index 5 afterwards: rdata=32'h0000A5C3, rresp=00.
- Split channels: awvalid at cycle 0, wvalid at cycle 3 (data 16'h1234, index 2).
  - Expected: awready=0 during cycles 1-3, commit at cycle 3, then bvalid.
  - Repeat with W first and AW second: same result.
- Out of range: write awaddr=32'h200 (index 128).
  - Expected: bresp=10, no register change, Wr_strobe stays 0.
  - Read the same address: rdata=0, rresp=10.
- Backpressure: bready=0 for 5 cycles after a write.
  - Expected: bvalid and bresp stable, awready=wready=0 throughout; a single handshake when bready rises.
  - Repeat on the read channel using rready.
- Simultaneous: index 7 holds 16'h0011; write 16'h0022 to index 7 and read index 7 in the same cycle.
  - Expected: rdata=0011, then a subsequent read returns 0022.
- Reset mid-write: assert Reset while in W_WAIT_W.
  - Expected: all outputs 0, registers 0; after release a fresh write completes normally.
